// File: rtl/wb_lcd_writer_if.sv
// Request/status and Wishbone bus bundle for the LCD writer.
// The master modport is the writer's view; the slave modport is the view
// of whatever sits on the other side (control source plus LCD slave).
interface wb_lcd_writer_if;
  // control side
  logic        req_i;
  logic [15:0] value_i;
  logic [3:0]  extras_i;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  // Wishbone side
  logic [3:0]  wb_adr_o;
  logic [7:0]  wb_dat_o;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_ack_i;

  modport master (
    input  req_i, value_i, extras_i, wb_ack_i,
    output busy_o, done_o, err_o,
    output wb_adr_o, wb_dat_o, wb_we_o, wb_cyc_o, wb_stb_o
  );

  modport slave (
    output req_i, value_i, extras_i, wb_ack_i,
    input  busy_o, done_o, err_o,
    input  wb_adr_o, wb_dat_o, wb_we_o, wb_cyc_o, wb_stb_o
  );
endinterface

// File: rtl/wb_lcd_writer.sv
// Wishbone classic-cycle master that writes a 16-bit hex value as four
// seven-segment patterns (DIGIT0..DIGIT3) followed by the colon/decimal-point
// flags (EXTRAS) into the LCD register slave. Every write is separated by a
// one-cycle gap so the slave sees a fresh strobe edge; each strobe phase is
// guarded by an ack timeout that aborts the whole sequence.
module wb_lcd_writer #(
  parameter int TIMEOUT = 15  // legal 2..255
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  wb_lcd_writer_if.master bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STROBE = 2'd1;
  localparam logic [1:0] S_GAP    = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  localparam logic [2:0] LAST_IDX  = 3'd4;
  localparam logic [7:0] CNT_LIMIT = 8'(TIMEOUT - 1);

  // sequencing state
  logic [1:0]  state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [15:0] val_q, val_d;
  logic [3:0]  ext_q, ext_d;
  logic [7:0]  cnt_q, cnt_d;

  // registered outputs (we/stb share the cyc flop: they are always equal)
  logic        cyc_q, cyc_d;
  logic [3:0]  adr_q, adr_d;
  logic [7:0]  dat_q, dat_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic [3:0]  nib;
  logic        strobe_next;
  logic        gap_next;

  // Hex nibble to segments, bit order {dp,g,f,e,d,c,b,a}, dp always off.
  function automatic logic [7:0] seg7(input logic [3:0] n);
    logic [7:0] s;
    case (n)
      4'h0: s = 8'h3F;
      4'h1: s = 8'h06;
      4'h2: s = 8'h5B;
      4'h3: s = 8'h4F;
      4'h4: s = 8'h66;
      4'h5: s = 8'h6D;
      4'h6: s = 8'h7D;
      4'h7: s = 8'h07;
      4'h8: s = 8'h7F;
      4'h9: s = 8'h6F;
      4'hA: s = 8'h77;
      4'hB: s = 8'h7C;
      4'hC: s = 8'h39;
      4'hD: s = 8'h5E;
      4'hE: s = 8'h79;
      default: s = 8'h71;
    endcase
    return s;
  endfunction

  // Sequencer: accept, strobe/ack, gap, finish, and the per-strobe timeout.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    val_d   = val_q;
    ext_d   = ext_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req_i) begin
          val_d   = bus.value_i;
          ext_d   = bus.extras_i;
          idx_d   = 3'd0;
          cnt_d   = 8'd0;
          state_d = S_STROBE;
        end
      end
      S_STROBE: begin
        // ack is checked first so an ack on the limit cycle still wins
        if (bus.wb_ack_i) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_FINISH;
          end else begin
            state_d = S_GAP;
            idx_d   = idx_q + 3'd1;
          end
        end else if (cnt_q == CNT_LIMIT) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_GAP: begin
        state_d = S_STROBE;
        cnt_d   = 8'd0;
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Pick the latched nibble that the next digit write will display.
  always_comb begin
    nib = val_d[3:0];
    case (idx_d)
      3'd1:    nib = val_d[7:4];
      3'd2:    nib = val_d[11:8];
      3'd3:    nib = val_d[15:12];
      default: nib = val_d[3:0];
    endcase
  end

  // Output values for the coming cycle, decoded from the next state so the
  // bus and status pins come straight off flops.
  always_comb begin
    strobe_next = (state_d == S_STROBE);
    gap_next    = (state_d == S_GAP);
    cyc_d       = strobe_next;
    busy_d      = strobe_next | gap_next;
    done_d      = (state_d == S_FINISH);
    adr_d       = 4'd0;
    dat_d       = 8'd0;
    if (strobe_next) begin
      adr_d = {1'b0, idx_d};
      if (idx_d == LAST_IDX) begin
        dat_d = {4'b0000, ext_d};
      end else begin
        dat_d = seg7(nib);
      end
    end
  end

  // State and output registers; reset drops the bus immediately.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      idx_q   <= 3'd0;
      val_q   <= 16'd0;
      ext_q   <= 4'd0;
      cnt_q   <= 8'd0;
      cyc_q   <= 1'b0;
      adr_q   <= 4'd0;
      dat_q   <= 8'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      val_q   <= val_d;
      ext_q   <= ext_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.wb_cyc_o = cyc_q;
  assign bus.wb_stb_o = cyc_q;
  assign bus.wb_we_o  = cyc_q;
  assign bus.wb_adr_o = adr_q;
  assign bus.wb_dat_o = dat_q;
  assign bus.busy_o   = busy_q;
  assign bus.done_o   = done_q;
  assign bus.err_o    = err_q;

endmodule

// File: tb/tb_wb_lcd_writer.sv
// Self-checking bench for wb_lcd_writer: a configurable LCD slave model
// (ack delay per address, no-ack, spurious ack while strobe is low) and a
// scoreboard of expected (adr,dat) writes compared as the bus accepts them.
module tb_wb_lcd_writer;

  localparam int TO = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  wb_lcd_writer_if bus ();

  wb_lcd_writer #(.TIMEOUT(TO)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0]  seg_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
  logic [11:0] exp_q [$];

  // slave model controls
  int   ack_at [16];
  bit   no_ack = 1'b0;
  bit   spur   = 1'b0;
  int   scnt;
  logic slv_ack;
  logic [7:0] slv_regs [16];

  // strobe-cycle counter: 0 in the first cycle of each strobe phase
  always @(posedge clk or posedge rst) begin
    if (rst) scnt <= 0;
    else if (bus.wb_stb_o) scnt <= scnt + 1;
    else scnt <= 0;
  end

  always_comb begin
    slv_ack = 1'b0;
    if (bus.wb_stb_o && !no_ack && (scnt >= ack_at[bus.wb_adr_o])) slv_ack = 1'b1;
    if (spur && !bus.wb_stb_o) slv_ack = 1'b1;
  end
  assign bus.wb_ack_i = slv_ack;

  always @(posedge clk) begin
    if (!rst && bus.wb_stb_o && bus.wb_we_o && slv_ack) slv_regs[bus.wb_adr_o] <= bus.wb_dat_o;
  end

  // observation results
  int obs_done_c, obs_n_done, obs_err_c, obs_n_err, obs_stb_c, obs_adr_max;
  bit obs_stop;

  task automatic set_slave_default();
    for (int i = 0; i < 16; i++) ack_at[i] = 1;
    no_ack = 1'b0;
    spur   = 1'b0;
  endtask

  task automatic start_req(input logic [15:0] v, input logic [3:0] e, input bit push, input bit hold);
    @(negedge clk);
    bus.req_i    = 1'b1;
    bus.value_i  = v;
    bus.extras_i = e;
    if (push) begin
      for (int i = 0; i < 4; i++) exp_q.push_back({4'(i), seg_tab[v[i*4 +: 4]]});
      exp_q.push_back({4'd4, 4'b0000, e});
    end
    @(posedge clk);  // E0
    #1;
    if (!hold) bus.req_i = 1'b0;
  endtask

  // Watch cycles 1..max_c after E0, popping the scoreboard on each accepted write.
  task automatic observe(input int max_c, input bit hold, input bit use_spur, input bit stop_adr2);
    logic [11:0] exp_w;
    int gaps;
    obs_done_c = 0; obs_n_done = 0; obs_err_c = 0; obs_n_err = 0;
    obs_stb_c = 0; obs_adr_max = 0; obs_stop = 1'b0; gaps = 0;
    for (int c = 1; c <= max_c; c++) begin
      @(negedge clk);
      if (stop_adr2 && bus.wb_stb_o && bus.wb_adr_o == 4'd2) begin
        obs_stop = 1'b1;
        spur = 1'b0;
        return;
      end
      if (bus.wb_stb_o) begin
        obs_stb_c++;
        if (int'(bus.wb_adr_o) > obs_adr_max) obs_adr_max = int'(bus.wb_adr_o);
      end
      if (bus.wb_stb_o && bus.wb_ack_i) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL sb_write cycle=%0d got adr=%0h dat=%02h we=%b expected no write",
                   c, bus.wb_adr_o, bus.wb_dat_o, bus.wb_we_o);
        end else begin
          exp_w = exp_q.pop_front();
          if ({bus.wb_we_o, bus.wb_adr_o, bus.wb_dat_o} !== {1'b1, exp_w}) begin
            failures++;
            $display("FAIL sb_write cycle=%0d got we=%b adr=%0h dat=%02h expected we=1 adr=%0h dat=%02h",
                     c, bus.wb_we_o, bus.wb_adr_o, bus.wb_dat_o, exp_w[11:8], exp_w[7:0]);
          end else begin
            $display("write cycle=%0d adr=%0h dat=%02h ok", c, bus.wb_adr_o, bus.wb_dat_o);
          end
        end
      end
      if (bus.done_o) begin
        obs_n_done++;
        if (obs_done_c == 0) obs_done_c = c;
        if (hold) bus.req_i = 1'b0;
      end
      if (bus.err_o) begin
        obs_n_err++;
        if (obs_err_c == 0) obs_err_c = c;
      end
      if (use_spur && bus.busy_o && !bus.wb_cyc_o) begin
        spur = (gaps == 0);
        gaps++;
      end
    end
    spur = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_adr_o, bus.wb_dat_o,
         bus.busy_o, bus.done_o, bus.err_o} !== 19'd0) begin
      failures++;
      $display("FAIL reset_outputs got cyc=%b stb=%b we=%b adr=%0h dat=%02h busy=%b done=%b err=%b expected all 0",
               bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_adr_o, bus.wb_dat_o,
               bus.busy_o, bus.done_o, bus.err_o);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.wb_cyc_o, bus.busy_o, bus.done_o, bus.err_o} !== 4'd0) begin
      failures++;
      $display("FAIL idle_after_reset got cyc=%b busy=%b done=%b err=%b expected 0",
               bus.wb_cyc_o, bus.busy_o, bus.done_o, bus.err_o);
    end
    $display("reset checked");
  endtask

  task automatic test_nominal();
    set_slave_default();
    start_req(16'h1234, 4'hA, 1'b1, 1'b0);
    observe(25, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs_done_c !== 15 || obs_n_done !== 1) begin
      failures++;
      $display("FAIL nominal_done got cycle=%0d count=%0d expected cycle=15 count=1", obs_done_c, obs_n_done);
    end
    checks++;
    if (obs_stb_c !== 10 || obs_n_err !== 0) begin
      failures++;
      $display("FAIL nominal_strobes got stb_cycles=%0d errs=%0d expected 10 and 0", obs_stb_c, obs_n_err);
    end
    checks++;
    if ({slv_regs[0], slv_regs[1], slv_regs[2], slv_regs[3], slv_regs[4]} !== 40'h664F5B060A) begin
      failures++;
      $display("FAIL nominal_regs got %02h %02h %02h %02h %02h expected 66 4F 5B 06 0A",
               slv_regs[0], slv_regs[1], slv_regs[2], slv_regs[3], slv_regs[4]);
    end
    checks++;
    if (exp_q.size() !== 0) begin
      failures++;
      $display("FAIL nominal_pending got %0d writes left expected 0", exp_q.size());
    end
    $display("nominal done_cycle=%0d", obs_done_c);
  endtask

  task automatic test_encoding();
    logic [15:0] vals [2];
    vals[0] = 16'hFEDC;
    vals[1] = 16'h89AB;
    set_slave_default();
    for (int k = 0; k < 2; k++) begin
      start_req(vals[k], 4'(k + 3), 1'b1, 1'b0);
      observe(18, 1'b0, 1'b0, 1'b0);
      checks++;
      if (obs_done_c !== 15 || exp_q.size() !== 0) begin
        failures++;
        $display("FAIL encoding_%04h got done_cycle=%0d pending=%0d expected 15 and 0",
                 vals[k], obs_done_c, exp_q.size());
      end
      $display("encoding value=%04h done_cycle=%0d", vals[k], obs_done_c);
    end
  endtask

  task automatic test_timeout();
    set_slave_default();
    no_ack = 1'b1;
    start_req(16'hBEEF, 4'hF, 1'b0, 1'b0);
    observe(30, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs_stb_c !== TO || obs_adr_max !== 0) begin
      failures++;
      $display("FAIL timeout_strobe got stb_cycles=%0d max_adr=%0d expected %0d and 0", obs_stb_c, obs_adr_max, TO);
    end
    checks++;
    if (obs_err_c !== TO + 1 || obs_n_err !== 1) begin
      failures++;
      $display("FAIL timeout_err got cycle=%0d count=%0d expected cycle=%0d count=1", obs_err_c, obs_n_err, TO + 1);
    end
    checks++;
    if (obs_n_done !== 0 || bus.busy_o !== 1'b0) begin
      failures++;
      $display("FAIL timeout_done got done_count=%0d busy=%b expected 0 and 0", obs_n_done, bus.busy_o);
    end
    $display("timeout err_cycle=%0d", obs_err_c);
    no_ack = 1'b0;
  endtask

  task automatic test_back_to_back();
    set_slave_default();
    ack_at[2] = 4;
    start_req(16'hC0DE, 4'h9, 1'b1, 1'b1);
    observe(35, 1'b1, 1'b1, 1'b0);
    checks++;
    if (obs_done_c !== 18 || obs_n_done !== 1) begin
      failures++;
      $display("FAIL waits_done got cycle=%0d count=%0d expected cycle=18 count=1", obs_done_c, obs_n_done);
    end
    checks++;
    if (obs_stb_c !== 13 || exp_q.size() !== 0 || obs_n_err !== 0) begin
      failures++;
      $display("FAIL waits_single got stb_cycles=%0d pending=%0d errs=%0d expected 13, 0, 0",
               obs_stb_c, exp_q.size(), obs_n_err);
    end
    $display("waits done_cycle=%0d", obs_done_c);
    ack_at[2] = 1;
  endtask

  task automatic test_boundary_ack();
    set_slave_default();
    ack_at[0] = TO - 1;
    start_req(16'h7531, 4'h6, 1'b1, 1'b0);
    observe(40, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs_n_err !== 0 || obs_done_c !== 28) begin
      failures++;
      $display("FAIL boundary_ack got errs=%0d done_cycle=%0d expected 0 and 28", obs_n_err, obs_done_c);
    end
    checks++;
    if (exp_q.size() !== 0) begin
      failures++;
      $display("FAIL boundary_pending got %0d expected 0", exp_q.size());
    end
    $display("boundary done_cycle=%0d", obs_done_c);
  endtask

  task automatic test_reset_midop();
    set_slave_default();
    start_req(16'h5A3C, 4'h5, 1'b1, 1'b0);
    observe(20, 1'b0, 1'b0, 1'b1);
    checks++;
    if (obs_stop !== 1'b1 || exp_q.size() !== 3) begin
      failures++;
      $display("FAIL midop_reach_adr2 got reached=%b pending=%0d expected 1 and 3", obs_stop, exp_q.size());
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_adr_o, bus.wb_dat_o,
         bus.busy_o, bus.done_o, bus.err_o} !== 19'd0) begin
      failures++;
      $display("FAIL midop_async_clear got cyc=%b stb=%b we=%b adr=%0h dat=%02h busy=%b expected all 0",
               bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_adr_o, bus.wb_dat_o, bus.busy_o);
    end
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    observe(6, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs_n_done !== 0 || obs_n_err !== 0 || obs_stb_c !== 0) begin
      failures++;
      $display("FAIL midop_quiet got done=%0d err=%0d stb_cycles=%0d expected 0 0 0", obs_n_done, obs_n_err, obs_stb_c);
    end
    start_req(16'h0000, 4'h0, 1'b1, 1'b0);
    observe(20, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs_done_c !== 15 || exp_q.size() !== 0 || obs_n_err !== 0) begin
      failures++;
      $display("FAIL midop_restart got done_cycle=%0d pending=%0d errs=%0d expected 15, 0, 0",
               obs_done_c, exp_q.size(), obs_n_err);
    end
    $display("reset_midop restart done_cycle=%0d", obs_done_c);
  endtask

  initial begin
    bus.req_i    = 1'b0;
    bus.value_i  = 16'd0;
    bus.extras_i = 4'd0;
    set_slave_default();
    for (int i = 0; i < 16; i++) slv_regs[i] = 8'd0;
    test_reset();
    test_nominal();
    test_encoding();
    test_timeout();
    test_back_to_back();
    test_boundary_ack();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_lcd_writer.md
# wb_lcd_writer

Wishbone classic-cycle master that pushes a 16-bit hex value plus colon/decimal-point flags into the 8-bit LCD register slave. On a single request it runs five back-to-back write cycles: DIGIT0..DIGIT3 with seven-segment patterns and EXTRAS with flags. It has per-cycle ack timeout and abort. It sits between a control source (button logic, counter, or CPU GPIO) and the LCD slave on the shared `wb_clk_i` domain.

## Interface
Parameters:
- `TIMEOUT`, 15: cycles a strobe may remain unacknowledged before abort; legal 2..255.

Ports:
- `wb_clk_i`  in  1  single clock for all logic.
- `wb_rst_i`  in  1  reset, asynchronous, active-high.
- `req_i`  in  1  start request; sampled only in IDLE.
- `value_i`  in  16  hex value; nibble n drives DIGITn (`value_i[3:0]` goes to DIGIT0).
- `extras_i`  in  4  bit3 = colon, bits2:0 = decimal points.
- `busy_o`  out  1  high while a sequence is in progress.
- `done_o`  out  1  one-cycle pulse after the fifth ack.
- `err_o`  out  1  one-cycle pulse on timeout abort.
- `wb_adr_o`  out  4  register address.
- `wb_dat_o`  out  8  write data.
- `wb_we_o`  out  1  write enable; always equals `wb_cyc_o`.
- `wb_cyc_o`  out  1  bus cycle.
- `wb_stb_o`  out  1  strobe.
- `wb_ack_i`  in  1  slave acknowledge.

## Operation
- All outputs are registered. The reset value of every output is 0.
- Acceptance:
  - In IDLE with `req_i`=1, latch `value_i` and `extras_i`, clear the index to 0, and go to STROBE.
  - `req_i` is ignored outside IDLE.
- States:
  - IDLE
  - STROBE: cyc/stb/we=1, adr=index, data=pattern.
  - GAP: cyc/stb/we=0.
  - FINISH: `done_o`=1.
- Transitions:
  - STROBE stays in STROBE until `wb_ack_i`=1 is sampled.
  - On ack with index<4: go to GAP and increment the index.
  - On ack with index=4: go to FINISH.
  - GAP goes to STROBE after exactly one cycle. The slave detects strobe edges, so the strobe must drop between writes.
  - FINISH goes to IDLE.
- Write data:
  - Index 0..3: seven-segment encoding of the latched nibble, bit order {dp,g,f,e,d,c,b,a}, dp=0.
  - Encoding: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, B=7C, C=39, D=5E, E=79, F=71.
  - Index 4: {4'b0000, latched extras}.
- Ack handling: `wb_ack_i` is sampled only in STROBE; acks in IDLE, GAP or FINISH are ignored.
- Timeout:
  - An 8-bit counter clears on entry to STROBE and increments each STROBE cycle without ack.
  - When it reaches `TIMEOUT`-1 without ack, the next edge drops cyc/stb, pulses `err_o`, discards the remaining writes, and returns to IDLE. No `done_o` is issued.
  - An ack arriving in the same cycle as the limit wins: no error.
- `busy_o`: 1 in STROBE and GAP; 0 in IDLE and FINISH.
- Reset mid-sequence: all outputs go to 0 immediately (asynchronous), state goes to IDLE, and no `done_o`/`err_o` is issued.

## Timing
- Let E0 be the edge that samples `req_i`=1 in IDLE.
- With the zero-wait LCD slave (ack combinational from a one-cycle-delayed strobe), each write takes 2 strobe cycles plus 1 gap cycle.
- Per-cycle sequence after E0:
  - Cycles 1–2: adr 0.
  - Cycle 3: gap.
  - Cycles 4–5: adr 1.
  - Cycle 6: gap.
  - Cycles 7–8: adr 2.
  - Cycle 9: gap.
  - Cycles 10–11: adr 3.
  - Cycle 12: gap.
  - Cycles 13–14: adr 4.
  - Cycle 15: `done_o`=1, `busy_o`=0.
- A new `req_i` is accepted at the earliest in cycle 16, i.e. the edge ending cycle 16.
- Slave wait states extend only the affected STROBE phase; the gap stays exactly 1 cycle.
- Error timing: `err_o` asserts in the cycle after the last timed-out strobe cycle. The strobe is high for exactly `TIMEOUT` cycles.

## Test plan
- Nominal: value_i=16'h1234, extras_i=4'hA, zero-wait slave model -> writes (0,4'h4=66),(1,3=4F),(2,2=5B),(3,1=06),(4,0A); `done_o` in cycle 15; slave registers read back the same values.
- Full encoding: value_i=16'hFEDC, then 16'h89AB -> DIGIT0..3 = 39,5E,79,71 then 7C,77,6F,7F.
- Timeout: slave never acks, TIMEOUT=15 -> stb high 15 cycles at adr 0, then `err_o` 1 cycle, no further cycles, `busy_o`=0, no `done_o`.
- Wait states and ignored requests: slave inserts 3 wait cycles on adr 2; `req_i` held high throughout and a spurious ack during GAP -> single sequence only; total 18 cycles to `done_o`; the spurious ack is ignored.
- Boundary ack: ack arrives exactly in the TIMEOUT-th strobe cycle -> write accepted, no `err_o`, sequence completes.
- Reset mid-op: assert `wb_rst_i` during adr 2 strobe -> cyc/stb/we/adr/dat=0 immediately; after release, IDLE; new req with 16'h0000 -> four writes of 3F and EXTRAS write of 00.
